// File: rtl/lsu_align_ctrl.sv
// lsu_align_ctrl: turns RISC-V byte/half/word loads and stores at any byte
// address into whole-word accesses on a word-only lsu. Sub-word stores are a
// single-cycle read-modify-write. Word-crossing accesses take two lsu cycles
// with a one-cycle pipeline stall and bump a saturating misalignment counter.
module lsu_align_ctrl #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              rdata_vld_o,
   output logic              stall_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  misalign_cnt_o,
   output logic [ADDR_W-1:0] lsu_addr_o,
   output logic [31:0]       lsu_st_data_o,
   output logic              lsu_st_en_o,
   input  logic [31:0]       lsu_ld_data_i
);

   typedef enum logic {IDLE, SPLIT2} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       lo_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [ADDR_W-1:0] cur_addr;
   logic [2:0]        cur_f3;
   logic              cur_we;
   logic [1:0]        off;
   logic [2:0]        size;
   logic [3:0]        size_mask;
   logic [7:0]        lane_mask;
   logic              legal;
   logic              fits;
   logic [2:0]        rem;
   logic [4:0]        lo_shift;
   logic [5:0]        hi_shift;
   logic [ADDR_W-1:0] word_addr;
   logic              capture;

   // Sign- or zero-extend the low bytes of a right-aligned raw value.
   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
      logic [31:0] res;
      case (f3[1:0])
         2'b00:   res = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
         2'b01:   res = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   // Replace the byte lanes selected by mask with the matching lanes of data.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] mask);
      logic [31:0] res;
      for (int k = 0; k < 4; k++) begin
         res[8*k +: 8] = mask[k] ? data[8*k +: 8] : old[8*k +: 8];
      end
      return res;
   endfunction

   // Decode the access currently being served: live inputs in IDLE, the captured copy in SPLIT2.
   always_comb begin
      cur_addr  = (state_q == SPLIT2) ? addr_q   : addr_i;
      cur_f3    = (state_q == SPLIT2) ? funct3_q : funct3_i;
      cur_we    = (state_q == SPLIT2) ? we_q     : mem_we_i;
      off       = cur_addr[1:0];
      case (cur_f3[1:0])
         2'b00:   begin size = 3'd1; size_mask = 4'b0001; end
         2'b01:   begin size = 3'd2; size_mask = 4'b0011; end
         default: begin size = 3'd4; size_mask = 4'b1111; end
      endcase
      case (cur_f3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~cur_we;
         default:                legal = 1'b0;
      endcase
      fits      = ({1'b0, off} + size) <= 3'd4;
      lane_mask = {4'b0000, size_mask} << off;
      rem       = 3'd4 - {1'b0, off};
      lo_shift  = {off, 3'b000};
      hi_shift  = {rem, 3'b000};
      word_addr = {cur_addr[ADDR_W-1:2], 2'b00};
   end

   // Next state and all lsu/pipeline strobes; everything is forced low while reset is held.
   always_comb begin
      state_d       = state_q;
      rdata_o       = '0;
      rdata_vld_o   = 1'b0;
      stall_o       = 1'b0;
      err_o         = 1'b0;
      lsu_st_en_o   = 1'b0;
      lsu_st_data_o = '0;
      lsu_addr_o    = word_addr;
      capture       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_req_i) begin
               if (!legal) begin
                  err_o = 1'b1;
               end else begin
                  if (cur_we) begin
                     lsu_st_en_o   = 1'b1;
                     lsu_st_data_o = merge(lsu_ld_data_i, wdata_i << lo_shift, lane_mask[3:0]);
                  end else if (fits) begin
                     rdata_o     = extend(lsu_ld_data_i >> lo_shift, cur_f3);
                     rdata_vld_o = 1'b1;
                  end
                  if (!fits) begin
                     stall_o = 1'b1;
                     capture = 1'b1;
                     state_d = SPLIT2;
                  end
               end
            end
         end
         SPLIT2: begin
            lsu_addr_o = word_addr + ADDR_W'(4);
            if (cur_we) begin
               lsu_st_en_o   = 1'b1;
               lsu_st_data_o = merge(lsu_ld_data_i, wdata_q >> hi_shift, lane_mask[7:4]);
            end else begin
               rdata_o     = extend(lo_q | (lsu_ld_data_i << hi_shift), cur_f3);
               rdata_vld_o = 1'b1;
            end
            state_d = IDLE;
         end
      endcase
      if (!rst_ni) begin
         state_d       = IDLE;
         rdata_o       = '0;
         rdata_vld_o   = 1'b0;
         stall_o       = 1'b0;
         err_o         = 1'b0;
         lsu_st_en_o   = 1'b0;
         lsu_st_data_o = '0;
         lsu_addr_o    = '0;
         capture       = 1'b0;
      end
   end

   // State register, split-access capture and saturating misalignment counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q   <= addr_i;
            funct3_q <= funct3_i;
            we_q     <= mem_we_i;
            wdata_q  <= wdata_i;
            if (!mem_we_i) begin
               lo_q <= lsu_ld_data_i >> lo_shift;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign misalign_cnt_o = cnt_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Testbench for lsu_align_ctrl: a byte-array memory model predicts every
// load result, store effect, stall and address, and a compare process checks
// the DUT against those predictions on every falling clock edge.
module tb_lsu_align_ctrl;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 16;

   logic        clk = 1'b0;
   logic        rstN;
   logic        memReq, memWe;
   logic [2:0]  funct3;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata, lsuStData, lsuLdData;
   logic        rdataVld, stall, err, lsuStEn;
   logic [15:0] misalignCnt;
   logic [11:0] lsuAddr;

   logic [31:0] sRdata, sStData, sLdData;
   logic        sVld, sStall, sErr, sStEn;
   logic [2:0]  sCnt;
   logic [11:0] sAddr;

   logic [31:0] lsuMem [1024];
   logic        clrEn, plEn;
   logic [9:0]  plIdx;
   logic [31:0] plVal;

   logic [7:0]  refMem [4096];
   int          cntModel;

   logic        chkEn;
   logic        eStall, eVld, eErr, eStEn;
   logic [31:0] eRdata;
   logic [11:0] eAddr;
   logic [31:0] lastRdata;

   int nCmp  = 0;
   int nFail = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   lsu_align_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rstN), .mem_req_i(memReq), .mem_we_i(memWe),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata), .rdata_vld_o(rdataVld), .stall_o(stall), .err_o(err),
      .misalign_cnt_o(misalignCnt), .lsu_addr_o(lsuAddr),
      .lsu_st_data_o(lsuStData), .lsu_st_en_o(lsuStEn), .lsu_ld_data_i(lsuLdData)
   );

   // A narrow-counter twin sharing the same inputs, so saturation is reachable in few cycles.
   lsu_align_ctrl #(.ADDR_W(ADDR_W), .CNT_W(3)) dutSat (
      .clk_i(clk), .rst_ni(rstN), .mem_req_i(memReq), .mem_we_i(memWe),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(sRdata), .rdata_vld_o(sVld), .stall_o(sStall), .err_o(sErr),
      .misalign_cnt_o(sCnt), .lsu_addr_o(sAddr),
      .lsu_st_data_o(sStData), .lsu_st_en_o(sStEn), .lsu_ld_data_i(sLdData)
   );

   assign lsuLdData = lsuMem[lsuAddr[11:2]];
   assign sLdData   = lsuMem[sAddr[11:2]];

   // Word-wide lsu: asynchronous read, synchronous write, plus bench-only clear/preload ports.
   always @(posedge clk) begin
      if (clrEn) begin
         for (int i = 0; i < 1024; i++) lsuMem[i] <= 32'h0;
      end else if (plEn) begin
         lsuMem[plIdx] <= plVal;
      end else if (lsuStEn) begin
         lsuMem[lsuAddr[11:2]] <= lsuStData;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int sizeOf(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit isLegal(input bit we, input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
      if (f3 == 3'd4 || f3 == 3'd5) return !we;
      return 1'b0;
   endfunction

   // Reference load: gather bytes addr..addr+s-1 (wrapping) and extend them.
   function automatic logic [31:0] modelLoad(input logic [11:0] a, input logic [2:0] f3);
      logic [31:0] v;
      int s;
      s = sizeOf(f3);
      v = 32'h0;
      for (int i = 0; i < s; i++) v[8*i +: 8] = refMem[(int'(a) + i) % 4096];
      if (!f3[2] && s == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && s == 2 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   function automatic logic [31:0] refWord(input int idx);
      return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
   endfunction

   // Compare every DUT output against the current expectations on each falling edge.
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("stall", {31'b0, stall}, {31'b0, eStall});
         checkOutput("rdata_vld", {31'b0, rdataVld}, {31'b0, eVld});
         checkOutput("err", {31'b0, err}, {31'b0, eErr});
         checkOutput("lsu_st_en", {31'b0, lsuStEn}, {31'b0, eStEn});
         checkOutput("lsu_addr", {20'b0, lsuAddr}, {20'b0, eAddr});
         if (eVld) begin
            checkOutput("rdata", rdata, eRdata);
            lastRdata = rdata;
         end
         checkOutput("misalign_cnt", {16'b0, misalignCnt}, (cntModel > 65535) ? 32'hFFFF : 32'(cntModel));
         checkOutput("sat_cnt", {29'b0, sCnt}, (cntModel > 7) ? 32'd7 : 32'(cntModel));
      end
   end

   // Drive an idle cycle with junk on the inputs and idle expectations.
   task automatic setIdle();
      memReq = 1'b0;
      memWe  = 1'($urandom);
      funct3 = 3'($urandom);
      addr   = 12'($urandom);
      wdata  = $urandom;
      eStall = 1'b0; eVld = 1'b0; eErr = 1'b0; eStEn = 1'b0;
      eAddr  = {addr[11:2], 2'b00};
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      setIdle();
      plEn = 1'b1; plIdx = 10'(idx); plVal = val;
      for (int i = 0; i < 4; i++) refMem[4*idx + i] = val[8*i +: 8];
      @(posedge clk); #1;
      plEn = 1'b0;
   endtask

   // One full MEM-stage access; entered and left one time unit after a rising edge.
   task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [11:0] a,
                                input logic [31:0] wd, input bit abortSplit = 1'b0);
      int s, o, hiIdx;
      bit lg, split;
      logic [11:0] w;
      s     = sizeOf(f3);
      o     = int'(a[1:0]);
      lg    = isLegal(we, f3);
      split = lg && (o + s > 4);
      w     = {a[11:2], 2'b00};
      memReq = 1'b1; memWe = we; funct3 = f3; addr = a; wdata = wd;
      eErr   = !lg;
      eStall = split;
      eVld   = lg && !split && !we;
      eStEn  = lg && we;
      eRdata = modelLoad(a, f3);
      eAddr  = w;
      @(posedge clk); #1;
      if (split) begin
         cntModel++;
         if (abortSplit) begin
            if (we) for (int i = 0; i < 4 - o; i++) refMem[(int'(a) + i) % 4096] = wd[8*i +: 8];
            rstN = 1'b0;
            cntModel = 0;
            eStall = 1'b0; eVld = 1'b0; eErr = 1'b0; eStEn = 1'b0; eAddr = 12'h000;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rstN = 1'b1;
         end else begin
            memReq = 1'($urandom); memWe = 1'($urandom); funct3 = 3'($urandom);
            addr = 12'($urandom); wdata = $urandom;
            eErr = 1'b0; eStall = 1'b0; eVld = !we; eStEn = we;
            eAddr = w + 12'd4;
            @(posedge clk); #1;
         end
      end
      if (lg && we && !abortSplit) begin
         for (int i = 0; i < s; i++) refMem[(int'(a) + i) % 4096] = wd[8*i +: 8];
      end
      setIdle();
      hiIdx = ((int'(a) + s - 1) % 4096) / 4;
      checkOutput("mem_lo_word", lsuMem[a[11:2]], refWord(int'(a[11:2])));
      checkOutput("mem_hi_word", lsuMem[hiIdx], refWord(hiIdx));
   endtask

   // Reset checks, directed cases with hand-computed results, then randomized traffic.
   initial begin
      chkEn = 1'b0; plEn = 1'b0; plIdx = '0; plVal = '0; lastRdata = '0;
      cntModel = 0;
      for (int i = 0; i < 4096; i++) refMem[i] = 8'h00;
      rstN = 1'b0; clrEn = 1'b1;
      memReq = 1'b1; memWe = 1'b1; funct3 = 3'b010; addr = 12'h123; wdata = 32'hA5A5A5A5;
      eStall = 1'b0; eVld = 1'b0; eErr = 1'b0; eStEn = 1'b0; eAddr = 12'h000; eRdata = '0;
      chkEn = 1'b1;
      @(posedge clk); #1;
      clrEn = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset_st_data", lsuStData, 32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);
      rstN = 1'b1;
      setIdle();
      @(posedge clk); #1;

      preload(0, 32'h44332211);
      preload(1, 32'h88776655);
      applyStimulus(1'b0, 3'b010, 12'h002, 32'h0);
      checkOutput("lw_0x002", lastRdata, 32'h66554433);
      checkOutput("lw_cnt", {16'b0, misalignCnt}, 32'd1);
      applyStimulus(1'b0, 3'b000, 12'h007, 32'h0);
      checkOutput("lb_0x007", lastRdata, 32'hFFFFFF88);
      applyStimulus(1'b0, 3'b100, 12'h007, 32'h0);
      checkOutput("lbu_0x007", lastRdata, 32'h00000088);
      applyStimulus(1'b0, 3'b001, 12'h003, 32'h0);
      checkOutput("lh_0x003", lastRdata, 32'h00005544);
      applyStimulus(1'b1, 3'b001, 12'h001, 32'h0000BEEF);
      checkOutput("sh_word0", lsuMem[0], 32'h44BEEF11);
      preload(0, 32'h44332211);
      applyStimulus(1'b1, 3'b010, 12'h003, 32'hDEADBEEF);
      checkOutput("sw_word0", lsuMem[0], 32'hEF332211);
      checkOutput("sw_word4", lsuMem[1], 32'h88DEADBE);
      preload(1023, 32'h11223344);
      preload(0, 32'h55667788);
      applyStimulus(1'b1, 3'b010, 12'hFFE, 32'hCAFEF00D);
      checkOutput("wrap_word_ffc", lsuMem[1023], 32'hF00D3344);
      checkOutput("wrap_word_000", lsuMem[0], 32'h5566CAFE);
      applyStimulus(1'b0, 3'b011, 12'h000, 32'h0);
      applyStimulus(1'b1, 3'b100, 12'h001, 32'h12345678);
      checkOutput("illegal_word0", lsuMem[0], 32'h5566CAFE);
      applyStimulus(1'b1, 3'b010, 12'h002, 32'h01020304, 1'b1);
      checkOutput("abort_word0", lsuMem[0], 32'h0304CAFE);
      checkOutput("abort_word4", lsuMem[1], 32'h88DEADBE);
      applyStimulus(1'b0, 3'b010, 12'h004, 32'h0);
      checkOutput("after_abort_lw", lastRdata, 32'h88DEADBE);

      for (int i = 0; i < 1024; i++) preload(i, $urandom);
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom), 3'($urandom), 12'($urandom), $urandom);
         if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
            setIdle();
         end
      end
      checkOutput("sat_literal", {29'b0, sCnt}, 32'd7);

      @(negedge clk);
      chkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
- Sits between the pipeline MEM stage and the word-wide lsu.
- Converts RISC-V byte/half/word loads and stores at any byte address into whole-word lsu accesses. The lsu only does full 32-bit stores, with an asynchronous read and a synchronous write.
- Sub-word stores become a single-cycle read-modify-write.
- Accesses that cross a word boundary are split into two lsu cycles, with a pipeline stall.
- Also keeps a saturating count of misaligned accesses.

Parameters:
- ADDR_W, 12, byte-address width of the lsu address port.
- CNT_W, 16, width of the misaligned-access counter.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- mem_req_i  in  1  MEM stage has a load/store this cycle.
- mem_we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, right-aligned.
- rdata_o  out  32  load result, sign- or zero-extended.
- rdata_vld_o  out  1  rdata_o valid this cycle.
- stall_o  out  1  pipeline must hold the MEM stage this cycle.
- err_o  out  1  illegal funct3 this cycle.
- misalign_cnt_o  out  CNT_W  count of word-crossing accesses.
- lsu_addr_o  out  ADDR_W  lsu address; bits [1:0] always 00.
- lsu_st_data_o  out  32  merged word to the lsu.
- lsu_st_en_o  out  1  lsu write enable.
- lsu_ld_data_i  in  32  lsu asynchronous read data.

Behaviour:
- Byte order and sizing
  - Little-endian: lane k = bits [8k+7:8k].
  - o = addr[1:0]; size s = 1/2/4 from funct3.
  - "Fits" means o+s <= 4; otherwise the access is "split".
- Reset
  - State = IDLE.
  - Capture registers, lo_q and misalign_cnt_o cleared to 0.
  - All outputs 0: stall_o, rdata_vld_o, err_o, lsu_st_en_o, rdata_o, lsu_addr_o, lsu_st_data_o.
  - Reset asserted during SPLIT2 aborts the access; no second write is issued.
- IDLE, mem_req_i=0
  - All strobes 0; lsu_addr_o = {addr_i[ADDR_W-1:2],00}.
- IDLE, illegal funct3
  - Illegal: 011, 110, 111, or a store with 100/101.
  - err_o=1, lsu_st_en_o=0, rdata_vld_o=0, stall_o=0 that cycle (combinational).
- IDLE, legal, fits (zero-stall, combinational)
  - Word address W = {addr[ADDR_W-1:2],00}.
  - Load: rdata_o = extend(lanes o..o+s-1 of lsu_ld_data_i); rdata_vld_o=1.
  - Store: lsu_st_data_o = lsu_ld_data_i with lanes o..o+s-1 replaced by wdata_i bytes 0..s-1; lsu_st_en_o=1.
  - Store write lands on the clock edge.
- IDLE, legal, split (cycle 1)
  - Access word W; stall_o=1.
  - Capture addr_i, funct3_i, mem_we_i and wdata_i.
  - Load: lo_q <= lanes o..3 of lsu_ld_data_i.
  - Store: write lanes o..3 with wdata bytes 0..3-o; lsu_st_en_o=1.
  - misalign_cnt_o += 1, saturating at all-ones.
  - Next state SPLIT2.
- SPLIT2 (cycle 2)
  - Uses captured values only; inputs are ignored.
  - lsu_addr_o = W+4, wrapping modulo 2^ADDR_W (0xFFC -> 0x000).
  - Load: rdata_o = extend({lanes 0..o+s-5 of lsu_ld_data_i, lo_q}); rdata_vld_o=1.
  - Store: lanes 0..o+s-5 get the remaining wdata bytes; lsu_st_en_o=1.
  - stall_o=0; next state IDLE.
  - The pipeline advances on this edge, so a new request may be presented in the following cycle.
- Extension and strobe rules
  - B/H sign-extend from bit 7/15; BU/HU zero-extend.
  - stall_o and lsu_st_en_o are never asserted outside the cases above.
  - lsu_st_en_o is never asserted for a load.

Test Plan:
- Load, misaligned and aligned: preload word0=0x44332211, word4=0x88776655.
  - LW at 0x002 -> cycle1 stall_o=1; cycle2 rdata_o=0x66554433, vld=1, misalign_cnt_o=1.
  - LB 0x007 -> 0xFFFFFF88.
  - LBU 0x007 -> 0x00000088.
  - LH 0x003 -> split, 0x00005544.
- SH 0xBEEF at 0x001 -> single cycle, stall_o=0; word0 becomes 0x44BEEF11.
- SW 0xDEADBEEF at 0x003 (word0=0x44332211, word4=0x88776655) -> two lsu writes; word0=0xEF332211, word4=0x88DEADBE; count +1.
- Address wrap: SW 0xCAFEF00D at 0xFFE -> word 0xFFC lanes 2..3 = F00D; word 0x000 lanes 0..1 = CAFE; second lsu_addr_o = 0x000.
- Illegal funct3 011, and store with 100 -> err_o=1, no lsu_st_en_o, memory unchanged.
- rst_ni low during SPLIT2 of a split SW -> only the first word written; outputs 0; state IDLE.
- Counter preloaded near max -> saturates at 0xFFFF.
